sigma_delta_modulator: RTL



---
 rtl/sdm_pkg.sv | 44 ++++
 rtl/sdm_sat_integrator.sv | 34 +++
 rtl/sigma_delta_modulator.sv | 114 +++++++++++
 3 files changed

// File: rtl/sdm_pkg.sv
// Shared constants, integrator word type and the saturating add used by both
// integrators of the second-order sigma-delta modulator.
package sdm_pkg;

   localparam int SDM_DATA_W = 8;
   localparam int SDM_INT_W  = 12;
   localparam int SDM_OSR    = 16;
   localparam int SDM_FS     = 2 ** (SDM_DATA_W - 1);

   typedef logic signed [SDM_INT_W-1:0] integ_t;

   typedef struct packed {
      logic               ovf;
      logic signed [31:0] val;
   } sat_res_t;

   // Operands are sign-extended to 32 bits, wide enough that acc + a - b never
   // wraps for any w up to 30; the result is then clamped to a w-bit range.
   function automatic sat_res_t sat_add(
      input logic signed [31:0] acc,
      input logic signed [31:0] a,
      input logic signed [31:0] b,
      input int                 w
   );
      logic signed [31:0] sum;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      sat_res_t           r;
      sum   = acc + a - b;
      hi    = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo    = -(32'sd1 <<< (w - 1));
      r.ovf = 1'b1;
      if (sum > hi) begin
         r.val = hi;
      end else if (sum < lo) begin
         r.val = lo;
      end else begin
         r.val = sum;
         r.ovf = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/sdm_sat_integrator.sv
// Clock-enabled delaying integrator: acc <= sat(acc + a - b).
// ovf flags a clamp on the update taking effect at the next clock edge.
module sdm_sat_integrator
   import sdm_pkg::*;
#(
   parameter int W = SDM_INT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] acc,
   output logic                ovf
);

   sat_res_t res;
   logic     sat_unused;

   always_comb res = sat_add(32'(acc), 32'(a), 32'(b), W);

   // Upper bits are pure sign extension of the clamped value.
   assign sat_unused = ^res.val[31:W];
   assign ovf        = en & res.ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= res.val[W-1:0];
      end
   end

endmodule

// File: rtl/sigma_delta_modulator.sv
// Second-order 1-bit sigma-delta modulator: PCM samples in at clk/OSR through
// a one-entry skid buffer, 1-bit stream out at clk rate.
module sigma_delta_modulator
   import sdm_pkg::*;
#(
   parameter int DATA_W = SDM_DATA_W,
   parameter int OSR    = SDM_OSR,
   parameter int INT_W  = SDM_INT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     bit_out,
   output logic                     frame_start,
   output logic                     underrun,
   output logic                     sat_flag
);

   localparam int                      CNT_W    = $clog2(OSR);
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(OSR - 1);
   localparam logic signed [INT_W-1:0] FS_W     = INT_W'(2 ** (DATA_W - 1));
   localparam logic signed [INT_W-1:0] FS2_W    = INT_W'(2 ** DATA_W);

   logic [CNT_W-1:0]         osr_cnt;
   logic                     buf_full;
   logic signed [DATA_W-1:0] buf_data;
   logic signed [DATA_W-1:0] x_reg;
   logic signed [INT_W-1:0]  x_ext;
   logic signed [INT_W-1:0]  v1;
   logic signed [INT_W-1:0]  v2;
   logic signed [INT_W-1:0]  i1;
   logic signed [INT_W-1:0]  i2;
   logic                     ovf1;
   logic                     ovf2;
   logic                     wrap;
   logic                     accept;

   assign in_ready    = ~buf_full;
   assign accept      = in_valid & ~buf_full;
   assign wrap        = en & (osr_cnt == CNT_LAST);
   assign frame_start = en & ~rst & (osr_cnt == '0);

   // i2 == 0 quantises to +FS.
   assign bit_out = ~i2[INT_W-1];
   assign x_ext   = {{(INT_W-DATA_W){x_reg[DATA_W-1]}}, x_reg};
   assign v1      = bit_out ? FS_W  : -FS_W;
   assign v2      = bit_out ? FS2_W : -FS2_W;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         osr_cnt <= '0;
      end else if (en) begin
         osr_cnt <= (osr_cnt == CNT_LAST) ? '0 : osr_cnt + 1'b1;
      end
   end

   // The skid buffer accepts regardless of en so the upstream handshake
   // keeps working while the loop is frozen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_full <= 1'b0;
         buf_data <= '0;
         x_reg    <= '0;
         underrun <= 1'b0;
      end else begin
         if (wrap) begin
            if (buf_full) begin
               x_reg <= buf_data;
            end else begin
               underrun <= 1'b1;
            end
         end
         if (accept) begin
            buf_data <= in_data;
            buf_full <= 1'b1;
         end else if (wrap) begin
            buf_full <= 1'b0;
         end
      end
   end

   sdm_sat_integrator #(.W(INT_W)) u_int1 (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (x_ext),
      .b   (v1),
      .acc (i1),
      .ovf (ovf1)
   );

   // Fed from the registered i1, so the second stage sees the previous value.
   sdm_sat_integrator #(.W(INT_W)) u_int2 (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (i1),
      .b   (v2),
      .acc (i2),
      .ovf (ovf2)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_flag <= 1'b0;
      end else if (ovf1 | ovf2) begin
         sat_flag <= 1'b1;
      end
   end

endmodule
